// File: rtl/lfsr_seq_checker.sv
// Self-synchronising receive checker for the XNOR LFSR bit stream: seeds, checks, locks, counts errors.
// Optional all-ones lockup detection is enabled by defining LFSR_CHK_STUCK_EN.
module lfsr_seq_checker #(
   parameter int unsigned WIDTH       = 9,
   parameter int unsigned TAP         = 4,
   parameter int unsigned LOCK_COUNT  = 16,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             bit_valid_i,
   input  logic             bit_in_i,
   input  logic             clr_err_i,
   output logic             locked_o,
   output logic             err_pulse_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic             stuck_o
);

   localparam int unsigned SeedW  = $clog2(WIDTH + 1);
   localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MissW  = $clog2(LOSS_THRESH + 1);

   localparam logic [SeedW-1:0]  SeedLast  = SeedW'(WIDTH - 1);
   localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
   localparam logic [MissW-1:0]  MissLast  = MissW'(LOSS_THRESH - 1);

   typedef enum logic [1:0] {StSeed, StCheck, StLocked} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   win_q, win_d;
   logic [SeedW-1:0]   seed_cnt_q, seed_cnt_d;
   logic [MatchW-1:0]  match_cnt_q, match_cnt_d;
   logic [MissW-1:0]   miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic               err_pulse_q, err_pulse_d;
   logic               stuck_q, stuck_d;

   logic               pred;
   logic               mismatch;
   logic [WIDTH-1:0]   shift_in;
   logic [WIDTH-1:0]   shift_pred;

   assign pred       = ~(win_q[0] ^ win_q[TAP]);
   assign mismatch   = bit_in_i ^ pred;
   assign shift_in   = {bit_in_i, win_q[WIDTH-1:1]};
   assign shift_pred = {pred, win_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_pulse_d = 1'b0;
`ifdef LFSR_CHK_STUCK_EN
      stuck_d     = stuck_q;
`else
      stuck_d     = 1'b0;
`endif
      // Clear applies first so a same-cycle error lands on top of zero.
      err_cnt_d   = clr_err_i ? '0 : err_cnt_q;

      if (bit_valid_i) begin
         unique case (state_q)
            StSeed: begin
               win_d = shift_in;
               if (seed_cnt_q == SeedLast) begin
                  state_d     = StCheck;
                  seed_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  seed_cnt_d = seed_cnt_q + SeedW'(1);
               end
            end
            StCheck: begin
               win_d = shift_in;
               if (mismatch) begin
                  match_cnt_d = '0;
               end else if (match_cnt_q == MatchLast) begin
                  state_d     = StLocked;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
               end else begin
                  match_cnt_d = match_cnt_q + MatchW'(1);
               end
            end
            StLocked: begin
               // Free-running reference: a corrupted input bit never enters the window.
               win_d = shift_pred;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
                  if (miss_cnt_q == MissLast) begin
                     state_d    = StSeed;
                     seed_cnt_d = '0;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + MissW'(1);
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end
            default: state_d = StSeed;
         endcase

`ifdef LFSR_CHK_STUCK_EN
         if (!bit_in_i) stuck_d = 1'b0;
         // All-ones is the XNOR lockup state; every prediction would match forever.
         if (state_q != StSeed && (&win_d)) begin
            stuck_d     = 1'b1;
            state_d     = StSeed;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StSeed;
         win_q       <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         stuck_q     <= stuck_d;
      end
   end

   assign locked_o    = (state_q == StLocked);
   assign err_pulse_o = err_pulse_q;
   assign err_count_o = err_cnt_q;
   assign stuck_o     = stuck_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, single error, idle, loss/relock, clear, saturation, all-ones.
// Expectations for the all-ones case follow whether LFSR_CHK_STUCK_EN is defined.
module tb_lfsr_seq_checker;

   logic        clk;
   logic        reset;
   logic        bit_valid;
   logic        bit_in;
   logic        clr_err;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic        stuck;
   logic        locked4;
   logic        err_pulse4;
   logic [3:0]  err_count4;
   logic        stuck4;

   logic [8:0]  gen;
   int          checks;
   int          errors;
   int          pulse_cnt;
   int          locked_seen;
   int          p0;

   lfsr_seq_checker dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .bit_valid_i (bit_valid),
      .bit_in_i    (bit_in),
      .clr_err_i   (clr_err),
      .locked_o    (locked),
      .err_pulse_o (err_pulse),
      .err_count_o (err_count),
      .stuck_o     (stuck)
   );

   lfsr_seq_checker #(.CNT_W(4)) dut4 (
      .clk_i       (clk),
      .reset_i     (reset),
      .bit_valid_i (bit_valid),
      .bit_in_i    (bit_in),
      .clr_err_i   (clr_err),
      .locked_o    (locked4),
      .err_pulse_o (err_pulse4),
      .err_count_o (err_count4),
      .stuck_o     (stuck4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_pulse) pulse_cnt++;
      if (locked) locked_seen = 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_raw(input logic b, input logic clr);
      bit_valid = 1'b1;
      bit_in    = b;
      clr_err   = clr;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      clr_err   = 1'b0;
   endtask

   // Drives generator bit 0 (optionally inverted), then steps the reference generator.
   task automatic send_bit(input logic inv, input logic clr);
      send_raw(gen[0] ^ inv, clr);
      gen = {~(gen[0] ^ gen[4]), gen[8:1]};
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
   endtask

   task automatic idle(input int n, input logic clr);
      for (int i = 0; i < n; i++) begin
         bit_valid = 1'b0;
         bit_in    = 1'($urandom);
         clr_err   = clr;
         @(posedge clk);
         #1;
      end
      clr_err = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bit_valid = 1'b0;
      clr_err   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      gen   = '0;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
      gen = '0; checks = 0; errors = 0; pulse_cnt = 0; locked_seen = 0;

      do_reset();
      check_eq("rst_locked", 32'(locked), 0);
      check_eq("rst_pulse", 32'(err_pulse), 0);
      check_eq("rst_count", 32'(err_count), 0);
      check_eq("rst_stuck", 32'(stuck), 0);

      // Lock on a clean stream: 9 seed + 16 matching bits.
      send_n(24);
      check_eq("t1_not_yet", 32'(locked), 0);
      send_n(1);
      check_eq("t1_locked", 32'(locked), 1);
      send_n(500);
      check_eq("t1_count", 32'(err_count), 0);
      check_eq("t1_still", 32'(locked), 1);

      // One corrupted bit gives exactly one error.
      p0 = pulse_cnt;
      send_n(39);
      send_bit(1'b1, 1'b0);
      check_eq("t2_pulse_hi", 32'(err_pulse), 1);
      send_n(1);
      check_eq("t2_pulse_lo", 32'(err_pulse), 0);
      send_n(199);
      check_eq("t2_pulses", 32'(pulse_cnt - p0), 1);
      check_eq("t2_count", 32'(err_count), 1);
      check_eq("t2_locked", 32'(locked), 1);

      // Gap in bit_valid holds everything.
      p0 = pulse_cnt;
      idle(30, 1'b0);
      check_eq("t3_locked", 32'(locked), 1);
      check_eq("t3_count", 32'(err_count), 1);
      send_n(50);
      check_eq("t3_pulses", 32'(pulse_cnt - p0), 0);
      check_eq("t3_count2", 32'(err_count), 1);

      // Clear, then lose lock on 4 consecutive misses and relock.
      idle(1, 1'b1);
      check_eq("t4_clr", 32'(err_count), 0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      check_eq("t4_lock3", 32'(locked), 1);
      check_eq("t4_count3", 32'(err_count), 3);
      send_bit(1'b1, 1'b0);
      check_eq("t4_lost", 32'(locked), 0);
      check_eq("t4_count4", 32'(err_count), 4);
      send_n(24);
      check_eq("t4_relock_early", 32'(locked), 0);
      send_n(1);
      check_eq("t4_relock", 32'(locked), 1);
      check_eq("t4_count_kept", 32'(err_count), 4);

      // Clear coinciding with a counted error, then clear alone.
      send_bit(1'b1, 1'b1);
      check_eq("t5_clr_err", 32'(err_count), 1);
      check_eq("t5_clr_pulse", 32'(err_pulse), 1);
      send_n(1);
      idle(1, 1'b1);
      check_eq("t5_clr_only", 32'(err_count), 0);
      check_eq("t5_clr_only4", 32'(err_count4), 0);

      // Isolated errors push the 4-bit counter into saturation.
      for (int i = 0; i < 19; i++) begin
         send_bit(1'b1, 1'b0);
         send_n(1);
      end
      send_bit(1'b1, 1'b0);
      check_eq("t5_sat4", 32'(err_count4), 15);
      check_eq("t5_sat4_pulse", 32'(err_pulse4), 1);
      check_eq("t5_count16", 32'(err_count), 20);
      send_n(1);
      check_eq("t5_locked", 32'(locked), 1);

      // Constant-ones stream after a mid-run reset.
      do_reset();
      check_eq("t6_rst_locked", 32'(locked), 0);
      check_eq("t6_rst_count", 32'(err_count), 0);
      for (int i = 0; i < 24; i++) send_raw(1'b1, 1'b0);
      check_eq("t6_not_yet", 32'(locked), 0);
      locked_seen = 0;
      for (int i = 0; i < 36; i++) send_raw(1'b1, 1'b0);
`ifdef LFSR_CHK_STUCK_EN
      check_eq("t6_stuck", 32'(stuck), 1);
      check_eq("t6_never_locked", 32'(locked_seen), 0);
      send_raw(1'b0, 1'b0);
      check_eq("t6_stuck_clr", 32'(stuck), 0);
`else
      check_eq("t6_stuck", 32'(stuck), 0);
      check_eq("t6_locked", 32'(locked), 1);
      check_eq("t6_locked_seen", 32'(locked_seen), 1);
`endif
      check_eq("t6_count", 32'(err_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
